// File: rtl/move_scheduler_if.sv
// rtl/move_scheduler_if.sv - command handshake between move_scheduler and the grid controller
interface move_scheduler_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;

  modport master (output cmd_valid, output cmd_op, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_op, output cmd_ready);
endinterface

// File: rtl/move_scheduler.sv
// rtl/move_scheduler.sv - once-per-frame arbiter turning key events and gravity ticks into grid commands
module move_scheduler #(
  parameter int unsigned MOVE_DELAY = 30
) (
  input  logic               vga_clk,
  input  logic               reset,
  input  logic [3:0]         op_keys,
  input  logic               draw_finish,
  input  logic               game_over,
  move_scheduler_if.master   cmd,
  output logic               busy
);

  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_ROT   = 3'd1;
  localparam logic [2:0] OP_LEFT  = 3'd2;
  localparam logic [2:0] OP_RIGHT = 3'd3;
  localparam logic [2:0] OP_DOWN  = 3'd4;
  localparam logic [2:0] OP_GRAV  = 3'd5;
  localparam logic [7:0] LAST     = 8'(MOVE_DELAY - 1);

  typedef enum logic [2:0] {IDLE, ARB, KEY_ISSUE, GRAV_CHECK, GRAV_ISSUE} state_t;

  state_t     state;
  logic [3:0] pending;
  logic [7:0] grav_cnt;
  logic       gravity_due;
  logic       frame_pending;

  logic       accept;
  logic       key_accept;
  logic       soft_down_accept;
  logic       grav_accept;
  logic [3:0] clr_mask;
  logic [2:0] arb_op;

  assign accept           = cmd.cmd_valid & cmd.cmd_ready;
  assign key_accept       = accept && (state == KEY_ISSUE);
  assign soft_down_accept = key_accept && (cmd.cmd_op == OP_DOWN);
  assign grav_accept      = accept && (state == GRAV_ISSUE);

  // Pending bit owned by the command currently on the bus.
  always_comb begin
    clr_mask = 4'b0000;
    case (cmd.cmd_op)
      OP_ROT:   clr_mask = 4'b0001;
      OP_LEFT:  clr_mask = 4'b0100;
      OP_RIGHT: clr_mask = 4'b1000;
      OP_DOWN:  clr_mask = 4'b0010;
      default:  clr_mask = 4'b0000;
    endcase
  end

  // Rotate beats left beats right beats down.
  always_comb begin
    arb_op = OP_NONE;
    if (pending[0])      arb_op = OP_ROT;
    else if (pending[2]) arb_op = OP_LEFT;
    else if (pending[3]) arb_op = OP_RIGHT;
    else if (pending[1]) arb_op = OP_DOWN;
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      state         <= IDLE;
      cmd.cmd_valid <= 1'b0;
      cmd.cmd_op    <= OP_NONE;
      busy          <= 1'b0;
      pending       <= 4'b0000;
      grav_cnt      <= 8'd0;
      gravity_due   <= 1'b0;
      frame_pending <= 1'b0;
    end else begin
      if (game_over)
        pending <= 4'b0000;
      else
        pending <= (pending & ~(key_accept ? clr_mask : 4'b0000)) | op_keys;

      // A fresh wrap in the same cycle as a gravity accept keeps gravity_due set.
      if (game_over) begin
        grav_cnt    <= 8'd0;
        gravity_due <= 1'b0;
      end else if (soft_down_accept) begin
        grav_cnt    <= 8'd0;
        gravity_due <= 1'b0;
      end else begin
        if (grav_accept)
          gravity_due <= 1'b0;
        if (draw_finish) begin
          if (grav_cnt >= LAST) begin
            grav_cnt    <= 8'd0;
            gravity_due <= 1'b1;
          end else begin
            grav_cnt <= grav_cnt + 8'd1;
          end
        end
      end

      if (draw_finish)
        frame_pending <= 1'b1;
      else if (state == IDLE && frame_pending && !game_over)
        frame_pending <= 1'b0;

      case (state)
        IDLE: begin
          if (frame_pending && !game_over) begin
            state <= ARB;
            busy  <= 1'b1;
          end
        end
        ARB: begin
          if (game_over) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (|pending) begin
            cmd.cmd_valid <= 1'b1;
            cmd.cmd_op    <= arb_op;
            state         <= KEY_ISSUE;
          end else begin
            state <= GRAV_CHECK;
          end
        end
        KEY_ISSUE: begin
          if (accept) begin
            cmd.cmd_valid <= 1'b0;
            cmd.cmd_op    <= OP_NONE;
            if (game_over) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state <= GRAV_CHECK;
            end
          end
        end
        GRAV_CHECK: begin
          if (gravity_due && !game_over) begin
            cmd.cmd_valid <= 1'b1;
            cmd.cmd_op    <= OP_GRAV;
            state         <= GRAV_ISSUE;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        GRAV_ISSUE: begin
          if (accept) begin
            cmd.cmd_valid <= 1'b0;
            cmd.cmd_op    <= OP_NONE;
            state         <= IDLE;
            busy          <= 1'b0;
          end
        end
        default: begin
          cmd.cmd_valid <= 1'b0;
          cmd.cmd_op    <= OP_NONE;
          state         <= IDLE;
          busy          <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_move_scheduler.sv
// tb/tb_move_scheduler.sv - directed bench for move_scheduler with MOVE_DELAY 3 and 4 instances
module tb_move_scheduler;

  logic       vga_clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] op_keys = 4'b0000;
  logic       draw_finish = 1'b0;
  logic       game_over = 1'b0;
  logic       cmd_ready = 1'b0;
  logic       busy3;
  logic       busy4;

  int n_checks = 0;
  int n_fail = 0;

  move_scheduler_if if3();
  move_scheduler_if if4();
  assign if3.cmd_ready = cmd_ready;
  assign if4.cmd_ready = cmd_ready;

  move_scheduler #(.MOVE_DELAY(3)) dut3 (
    .vga_clk(vga_clk), .reset(reset), .op_keys(op_keys), .draw_finish(draw_finish),
    .game_over(game_over), .cmd(if3.master), .busy(busy3)
  );

  move_scheduler #(.MOVE_DELAY(4)) dut4 (
    .vga_clk(vga_clk), .reset(reset), .op_keys(op_keys), .draw_finish(draw_finish),
    .game_over(game_over), .cmd(if4.master), .busy(busy4)
  );

  always #5 vga_clk = ~vga_clk;

  // Accepted command log, one octal digit per command, cleared by reset.
  logic [31:0] seq3, seq4;
  int n3, n4, vcnt3, passes3;
  logic busy3_q;

  always @(negedge vga_clk) begin
    if (reset) begin
      seq3 = 32'd0; seq4 = 32'd0; n3 = 0; n4 = 0; vcnt3 = 0; passes3 = 0; busy3_q = 1'b0;
    end else begin
      if (if3.cmd_valid && cmd_ready) begin seq3 = {seq3[28:0], if3.cmd_op}; n3++; end
      if (if4.cmd_valid && cmd_ready) begin seq4 = {seq4[28:0], if4.cmd_op}; n4++; end
      if (if3.cmd_valid) vcnt3++;
      if (busy3 && !busy3_q) passes3++;
      busy3_q = busy3;
    end
  end

  task automatic cyc();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  task automatic pulse();
    draw_finish = 1'b1;
    cyc();
    draw_finish = 1'b0;
  endtask

  task automatic key(input logic [3:0] k);
    op_keys = k;
    cyc();
    op_keys = 4'b0000;
  endtask

  task automatic do_reset();
    reset = 1'b1; op_keys = 4'b0000; draw_finish = 1'b0; game_over = 1'b0; cmd_ready = 1'b0;
    run(2);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (if3.cmd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", if3.cmd_valid); end
    n_checks++; if (if3.cmd_op !== 3'd0) begin n_fail++; $display("FAIL reset_op: got %0d expected 0", if3.cmd_op); end
    n_checks++; if (busy3 !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy3); end
    n_checks++; if (dut3.pending !== 4'b0000) begin n_fail++; $display("FAIL reset_pending: got %b expected 0000", dut3.pending); end
    n_checks++; if (dut3.grav_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d expected 0", dut3.grav_cnt); end
    n_checks++; if (dut3.frame_pending !== 1'b0) begin n_fail++; $display("FAIL reset_fp: got %b expected 0", dut3.frame_pending); end
  endtask

  task automatic test_gravity();
    do_reset();
    cmd_ready = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      pulse();
      run(8);
      n_checks++; if (n3 !== k / 3) begin n_fail++; $display("FAIL gravity_count_after_%0d: got %0d expected %0d", k, n3, k / 3); end
    end
    n_checks++; if (seq3 !== 32'o55) begin n_fail++; $display("FAIL gravity_ops: got %o expected 55", seq3); end
    n_checks++; if (seq4 !== 32'o5) begin n_fail++; $display("FAIL gravity_ops_d4: got %o expected 5", seq4); end
  endtask

  task automatic test_left_right();
    do_reset();
    cmd_ready = 1'b1;
    key(4'b1100);
    pulse();
    run(8);
    n_checks++; if (seq3 !== 32'o2) begin n_fail++; $display("FAIL lr_pass1: got %o expected 2", seq3); end
    pulse();
    run(8);
    n_checks++; if (seq3 !== 32'o23) begin n_fail++; $display("FAIL lr_pass2: got %o expected 23", seq3); end
    n_checks++; if (dut3.pending !== 4'b0000) begin n_fail++; $display("FAIL lr_pending: got %b expected 0000", dut3.pending); end
  endtask

  task automatic test_priority();
    do_reset();
    cmd_ready = 1'b1;
    key(4'b1111);
    pulse();
    run(8);
    n_checks++; if (n3 !== 1) begin n_fail++; $display("FAIL prio_one_per_pass: got %0d expected 1", n3); end
    repeat (3) begin pulse(); run(8); end
    n_checks++; if (seq3 !== 32'o12354) begin n_fail++; $display("FAIL prio_order: got %o expected 12354", seq3); end
    n_checks++; if (seq4 !== 32'o1234) begin n_fail++; $display("FAIL prio_order_d4: got %o expected 1234", seq4); end
  endtask

  task automatic test_stall();
    int p0;
    do_reset();
    key(4'b0001);
    pulse();
    run(3);
    p0 = passes3;
    n_checks++; if (p0 !== 1) begin n_fail++; $display("FAIL stall_first_pass: got %0d expected 1", p0); end
    for (int i = 0; i < 10; i++) begin
      draw_finish = (i == 2 || i == 5);
      cyc();
      n_checks++; if ({if3.cmd_valid, if3.cmd_op} !== 4'b1001) begin n_fail++; $display("FAIL stall_hold_%0d: got %b expected 1001", i, {if3.cmd_valid, if3.cmd_op}); end
    end
    draw_finish = 1'b0;
    cmd_ready = 1'b1;
    run(20);
    n_checks++; if (seq3 !== 32'o15) begin n_fail++; $display("FAIL stall_ops: got %o expected 15", seq3); end
    n_checks++; if (passes3 !== 2) begin n_fail++; $display("FAIL stall_passes: got %0d expected 2", passes3); end
    n_checks++; if (seq4 !== 32'o1) begin n_fail++; $display("FAIL stall_ops_d4: got %o expected 1", seq4); end
  endtask

  task automatic test_soft_down_boundary();
    do_reset();
    cmd_ready = 1'b1;
    pulse(); run(8);
    pulse(); run(8);
    cmd_ready = 1'b0;
    key(4'b0010);
    pulse();
    run(3);
    n_checks++; if (dut4.grav_cnt !== 8'd3) begin n_fail++; $display("FAIL sd_cnt_before: got %0d expected 3", dut4.grav_cnt); end
    n_checks++; if ({if4.cmd_valid, if4.cmd_op} !== 4'b1100) begin n_fail++; $display("FAIL sd_offer: got %b expected 1100", {if4.cmd_valid, if4.cmd_op}); end
    cmd_ready = 1'b1;
    draw_finish = 1'b1;
    cyc();
    draw_finish = 1'b0;
    n_checks++; if (dut4.grav_cnt !== 8'd0) begin n_fail++; $display("FAIL sd_cnt_after: got %0d expected 0", dut4.grav_cnt); end
    n_checks++; if (dut4.gravity_due !== 1'b0) begin n_fail++; $display("FAIL sd_due_after: got %b expected 0", dut4.gravity_due); end
    run(20);
    n_checks++; if (seq4 !== 32'o4) begin n_fail++; $display("FAIL sd_ops_d4: got %o expected 4", seq4); end
    n_checks++; if (seq3 !== 32'o4) begin n_fail++; $display("FAIL sd_ops_d3: got %o expected 4", seq3); end
  endtask

  task automatic test_game_over();
    do_reset();
    cmd_ready = 1'b1;
    key(4'b1111);
    n_checks++; if (dut3.pending !== 4'b1111) begin n_fail++; $display("FAIL go_pending_set: got %b expected 1111", dut3.pending); end
    game_over = 1'b1;
    cyc();
    n_checks++; if (dut3.pending !== 4'b0000) begin n_fail++; $display("FAIL go_pending_clr: got %b expected 0000", dut3.pending); end
    repeat (3) begin pulse(); run(8); end
    n_checks++; if (vcnt3 !== 0) begin n_fail++; $display("FAIL go_no_valid: got %0d expected 0", vcnt3); end
    n_checks++; if (dut3.grav_cnt !== 8'd0) begin n_fail++; $display("FAIL go_cnt: got %0d expected 0", dut3.grav_cnt); end
    game_over = 1'b0;
    run(10);
    n_checks++; if (vcnt3 !== 0) begin n_fail++; $display("FAIL go_release_idle: got %0d expected 0", vcnt3); end
    key(4'b0001);
    pulse();
    run(8);
    n_checks++; if (seq3 !== 32'o1) begin n_fail++; $display("FAIL go_recover: got %o expected 1", seq3); end
  endtask

  task automatic test_game_over_inflight();
    do_reset();
    key(4'b0001);
    pulse();
    run(3);
    game_over = 1'b1;
    run(3);
    n_checks++; if ({if3.cmd_valid, if3.cmd_op} !== 4'b1001) begin n_fail++; $display("FAIL goi_hold: got %b expected 1001", {if3.cmd_valid, if3.cmd_op}); end
    cmd_ready = 1'b1;
    cyc();
    n_checks++; if (if3.cmd_valid !== 1'b0) begin n_fail++; $display("FAIL goi_accept: got %b expected 0", if3.cmd_valid); end
    n_checks++; if (busy3 !== 1'b0) begin n_fail++; $display("FAIL goi_idle: got %b expected 0", busy3); end
    run(5);
    n_checks++; if (n3 !== 1) begin n_fail++; $display("FAIL goi_count: got %0d expected 1", n3); end
    game_over = 1'b0;
  endtask

  task automatic test_reset_mid_issue();
    do_reset();
    repeat (3) begin pulse(); run(8); end
    n_checks++; if ({if3.cmd_valid, if3.cmd_op} !== 4'b1101) begin n_fail++; $display("FAIL rmi_offer: got %b expected 1101", {if3.cmd_valid, if3.cmd_op}); end
    reset = 1'b1; op_keys = 4'b1111; draw_finish = 1'b1; cmd_ready = 1'b1;
    cyc();
    n_checks++; if ({if3.cmd_valid, if3.cmd_op} !== 4'b0000) begin n_fail++; $display("FAIL rmi_cmd: got %b expected 0000", {if3.cmd_valid, if3.cmd_op}); end
    n_checks++; if (busy3 !== 1'b0) begin n_fail++; $display("FAIL rmi_busy: got %b expected 0", busy3); end
    n_checks++; if (dut3.pending !== 4'b0000) begin n_fail++; $display("FAIL rmi_pending: got %b expected 0000", dut3.pending); end
    n_checks++; if (dut3.grav_cnt !== 8'd0) begin n_fail++; $display("FAIL rmi_cnt: got %0d expected 0", dut3.grav_cnt); end
    n_checks++; if (dut3.gravity_due !== 1'b0) begin n_fail++; $display("FAIL rmi_due: got %b expected 0", dut3.gravity_due); end
    n_checks++; if (dut3.frame_pending !== 1'b0) begin n_fail++; $display("FAIL rmi_fp: got %b expected 0", dut3.frame_pending); end
    reset = 1'b0; op_keys = 4'b0000; draw_finish = 1'b0; cmd_ready = 1'b0;
    cyc();
  endtask

  initial begin
    test_reset();
    test_gravity();
    test_left_right();
    test_priority();
    test_stall();
    test_soft_down_boundary();
    test_game_over();
    test_game_over_inflight();
    test_reset_mid_issue();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
